comparador_serial_der_izq: RTL and testbench
============================================

COMPARADOR_SERIAL_DER_IZQ -- requirements
Module: comparador_serial_der_izq

Interface
REQ-001 Parameter N, default 8: width of words A and B (N >= 2).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a comparison; sampled only in state IDLE.
REQ-005 A  input  N  first operand; captured on accepted start.
REQ-006 B  input  N  second operand; captured on accepted start.
REQ-007 busy  output  1  high while a comparison is in progress (states LOAD, SHIFT).
REQ-008 done  output  1  one-cycle pulse when the result becomes valid.
REQ-009 estado  output  2  result code: 01 = a (A==B), 10 = b (A>B), 11 = c (A<B), 00 = no result.
REQ-010 Zout  output  1  high iff estado == 10 (A > B).

Function
REQ-011 Compare bit pairs serially, right to left (LSB first), one pair per cycle, using the same a/b/c state code as the combinational left-to-right network.
REQ-012 Use FSM states IDLE, LOAD, SHIFT and DONE.
REQ-013 IDLE: if start = 1 on a rising edge, capture A and B into shift registers, clear the bit counter, and go to LOAD; otherwise stay in IDLE.
REQ-014 LOAD: set the working state to a (01) and go to SHIFT; A/B inputs are ignored from this point until the next accepted start.
REQ-015 Cell update rule per SHIFT cycle, for current bits Ai and Bi:
  - Ai == Bi: keep the working state.
  - Ai = 1, Bi = 0: working state becomes b (10).
  - Ai = 0, Bi = 1: working state becomes c (11).
  - Because a more significant bit overrides all earlier (less significant) decisions, the final state equals the MSB-first comparison.
REQ-016 SHIFT: each cycle, shift both registers right by one and increment the counter (width ceil(log2 N)).
REQ-017 After bit N-1 is processed, go to DONE; the counter is never compared beyond N-1 and does not wrap during an operation.
REQ-018 DONE: load the working state into estado, pulse done for exactly one cycle, and go to IDLE on the next edge.
REQ-019 Latency: done is high in the cycle following the (N+2)th rising edge after the edge that sampled start (N = 8: 10 edges).
REQ-020 estado and Zout hold their last value from DONE until the next DONE; they are not cleared by a new start.
REQ-021 busy = 1 exactly in LOAD and SHIFT; busy and done are never high simultaneously.
REQ-022 start while the FSM is in LOAD, SHIFT or DONE is ignored (no queuing).
REQ-023 start held high continuously is accepted again in IDLE, giving back-to-back operations with one IDLE cycle between them.
REQ-024 All outputs are registered; there is no combinational path from any input to any output.

Reset
REQ-025 While reset = 1, asynchronously force: FSM = IDLE, busy = 0, done = 0, estado = 00, Zout = 0, counter and shift registers = 0.
REQ-026 Reset asserted mid-operation aborts the comparison with no done pulse; after release, the first start is accepted normally.
REQ-027 On the first rising edge after reset deasserts, the block is in IDLE and may accept start.

Verification
REQ-028 N = 8, A = 8'h5A, B = 8'h5A, start pulse -> done after 10 edges, estado = 01, Zout = 0.
REQ-029 A = 8'h80, B = 8'h7F -> estado = 10, Zout = 1 (MSB overrides opposing LSBs); A = 8'h01, B = 8'h02 -> estado = 11, Zout = 0.
REQ-030 Exhaustive sweep with N = 2 (all 16 A/B pairs) -> estado matches the MSB-first reference comparison for every pair.
REQ-031 Start with A = 8'hFF, B = 8'h00, then pulse start again with different operands while busy = 1 -> second start ignored; result estado = 10.
REQ-032 Reset asserted on the 4th SHIFT cycle -> no done pulse; outputs read 00/0/0 during reset; next full operation completes correctly.
REQ-033 start held high for three operations -> three done pulses spaced N+3 cycles apart, each with the correct estado.

Source files
------------

// File: rtl/comparador_serial_der_izq.sv
// Serial magnitude comparator, LSB first (right to left).
// Walks the bit pairs of A and B one per cycle; because every more
// significant difference overrides earlier decisions, the final working
// state equals the MSB-first comparison result.
//   estado: 01 = A==B, 10 = A>B, 11 = A<B, 00 = no result yet.
module comparador_serial_der_izq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [1:0]   estado,
  output logic         Zout
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] ST_A = 2'b01;  // equal so far
  localparam logic [1:0] ST_B = 2'b10;  // A greater
  localparam logic [1:0] ST_C = 2'b11;  // A smaller

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t         state;
  logic [N-1:0]   sh_a;
  logic [N-1:0]   sh_b;
  logic [CW-1:0]  cnt;
  logic [1:0]     work;

  // One comparator cell: a differing bit pair decides, equal bits keep the
  // decision taken by the less significant bits.
  function automatic logic [1:0] cell_next(input logic [1:0] cur,
                                           input logic       ai,
                                           input logic       bi);
    if (ai && !bi)      return ST_B;
    else if (!ai && bi) return ST_C;
    else                return cur;
  endfunction

  // Control FSM with registered outputs; the result is published on the
  // edge that leaves DONE so that estado and done change together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      sh_a   <= '0;
      sh_b   <= '0;
      cnt    <= '0;
      work   <= 2'b00;
      busy   <= 1'b0;
      done   <= 1'b0;
      estado <= 2'b00;
      Zout   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= A;
            sh_b  <= B;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          work  <= ST_A;
          state <= SHIFT;
        end
        SHIFT: begin
          work <= cell_next(work, sh_a[0], sh_b[0]);
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          // Stop on the last bit instead of letting the counter wrap.
          if (cnt == LAST) begin
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          estado <= work;
          Zout   <= (work == ST_B);
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// Testbench for comparador_serial_der_izq: an N=8 instance for most
// scenarios plus an N=2 instance for the exhaustive small-width sweep.
module tb_comparador_serial_der_izq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic       busy, done, Zout;
  logic [1:0] estado;

  logic       start2 = 1'b0;
  logic [1:0] A2 = '0;
  logic [1:0] B2 = '0;
  logic       busy2, done2, Zout2;
  logic [1:0] estado2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  comparador_serial_der_izq #(.N(8)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .estado(estado), .Zout(Zout)
  );

  comparador_serial_der_izq #(.N(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .A(A2), .B(B2),
    .busy(busy2), .done(done2), .estado(estado2), .Zout(Zout2)
  );

  // Reference: plain magnitude comparison of the whole words.
  function automatic logic [1:0] ref_cmp(input int unsigned a, input int unsigned b);
    if (a == b)     return 2'b01;
    else if (a > b) return 2'b10;
    else            return 2'b11;
  endfunction

  // Runs one operation on the N=8 instance and reports what was observed.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [1:0] est, output logic z,
                        output int busy_cnt, output logic [1:0] est_early,
                        output logic clash);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    est_early = estado;
    busy_cnt = busy ? 1 : 0;
    clash = busy & done;
    lat = -1; est = 2'bxx; z = 1'bx;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (busy && done) clash = 1'b1;
      if (done) begin
        lat = k; est = estado; z = Zout;
        break;
      end
    end
  endtask

  task automatic run_op2(input logic [1:0] a, input logic [1:0] b,
                         output int lat, output logic [1:0] est, output logic z);
    @(negedge clk);
    A2 = a; B2 = b; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = -1; est = 2'bxx; z = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done2) begin
        lat = k; est = estado2; z = Zout2;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (estado !== 2'b00)   begin bad++; $display("FAIL reset_estado got=%b want=00", estado); end
    total++; if (Zout !== 1'b0)      begin bad++; $display("FAIL reset_zout got=%b want=0", Zout); end
    total++; if (estado2 !== 2'b00)  begin bad++; $display("FAIL reset_estado_n2 got=%b want=00", estado2); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [7:0] va [3] = '{8'h5A, 8'h80, 8'h01};
    logic [7:0] vb [3] = '{8'h5A, 8'h7F, 8'h02};
    logic [1:0] prev = 2'b00;
    int lat, bc; logic [1:0] est, ee; logic z, cl;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], lat, est, z, bc, ee, cl);
      total++; if (lat !== 10) begin bad++; $display("FAIL dir_latency[%0d] got=%0d want=10", i, lat); end
      total++; if (est !== ref_cmp(va[i], vb[i])) begin bad++; $display("FAIL dir_estado[%0d] got=%b want=%b", i, est, ref_cmp(va[i], vb[i])); end
      total++; if (z !== (ref_cmp(va[i], vb[i]) == 2'b10)) begin bad++; $display("FAIL dir_zout[%0d] got=%b want=%b", i, z, ref_cmp(va[i], vb[i]) == 2'b10); end
      total++; if (bc !== 9) begin bad++; $display("FAIL dir_busy_cycles[%0d] got=%0d want=9", i, bc); end
      total++; if (cl !== 1'b0) begin bad++; $display("FAIL dir_busy_done_overlap[%0d] got=%b want=0", i, cl); end
      total++; if (ee !== prev) begin bad++; $display("FAIL dir_estado_hold[%0d] got=%b want=%b", i, ee, prev); end
      prev = ref_cmp(va[i], vb[i]);
    end
  endtask

  task automatic test_random;
    int lat, bc; logic [1:0] est, ee; logic z, cl;
    logic [7:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      b = (i % 4 == 0) ? a : 8'($urandom);
      run_op(a, b, lat, est, z, bc, ee, cl);
      total++;
      if (lat !== 10 || est !== ref_cmp(a, b) || z !== (ref_cmp(a, b) == 2'b10))
        begin bad++; $display("FAIL rand A=%h B=%h got lat=%0d est=%b z=%b want lat=10 est=%b z=%b",
                               a, b, lat, est, z, ref_cmp(a, b), ref_cmp(a, b) == 2'b10); end
    end
  endtask

  task automatic test_exhaustive_n2;
    int lat; logic [1:0] est; logic z;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        run_op2(2'(a), 2'(b), lat, est, z);
        total++;
        if (lat !== 4 || est !== ref_cmp(a, b) || z !== (ref_cmp(a, b) == 2'b10))
          begin bad++; $display("FAIL n2 A=%0d B=%0d got lat=%0d est=%b z=%b want lat=4 est=%b z=%b",
                                 a, b, lat, est, z, ref_cmp(a, b), ref_cmp(a, b) == 2'b10); end
      end
    end
  endtask

  task automatic test_busy_ignore;
    int lat = -1; int extra = 0;
    @(negedge clk);
    A = 8'hFF; B = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 3) begin A = 8'h00; B = 8'hFF; start = 1'b1; end
      if (k == 4) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    total++; if (lat !== 10) begin bad++; $display("FAIL busy_ign_latency got=%0d want=10", lat); end
    total++; if (estado !== 2'b10) begin bad++; $display("FAIL busy_ign_estado got=%b want=10", estado); end
    total++; if (Zout !== 1'b1) begin bad++; $display("FAIL busy_ign_zout got=%b want=1", Zout); end
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL busy_ign_queued got=%0d active cycles want=0", extra); end
  endtask

  task automatic test_reset_mid;
    int dcnt = 0;
    int lat, bc; logic [1:0] est, ee; logic z, cl;
    @(negedge clk);
    A = 8'h01; B = 8'h02; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    total++; if (estado !== 2'b00 || Zout !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL rst_mid_outputs got est=%b z=%b busy=%b done=%b want 00/0/0/0", estado, Zout, busy, done); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (estado !== 2'b00 || busy !== 1'b0)
      begin bad++; $display("FAIL rst_mid_hold got est=%b busy=%b want 00/0", estado, busy); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    total++; if (dcnt !== 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d want=0", dcnt); end
    run_op(8'h3C, 8'h3D, lat, est, z, bc, ee, cl);
    total++; if (lat !== 10 || est !== 2'b11 || z !== 1'b0)
      begin bad++; $display("FAIL rst_mid_recover got lat=%0d est=%b z=%b want 10/11/0", lat, est, z); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] va [3] = '{8'h10, 8'h22, 8'h7E};
    logic [7:0] vb [3] = '{8'h20, 8'h22, 8'h7D};
    int at [3] = '{-1, -1, -1};
    int n = 0;
    @(negedge clk);
    A = va[0]; B = vb[0]; start = 1'b1;
    for (int k = 0; k <= 60 && n < 3; k++) begin
      @(posedge clk); #1;
      if (done) begin
        at[n] = k;
        total++; if (estado !== ref_cmp(va[n], vb[n]))
          begin bad++; $display("FAIL b2b_estado[%0d] got=%b want=%b", n, estado, ref_cmp(va[n], vb[n])); end
        n++;
        if (n < 3) begin A = va[n]; B = vb[n]; end
        else start = 1'b0;
      end
    end
    start = 1'b0;
    total++; if (at[0] !== 10) begin bad++; $display("FAIL b2b_first got=%0d want=10", at[0]); end
    total++; if (at[1] - at[0] !== 11) begin bad++; $display("FAIL b2b_gap1 got=%0d want=11", at[1] - at[0]); end
    total++; if (at[2] - at[1] !== 11) begin bad++; $display("FAIL b2b_gap2 got=%0d want=11", at[2] - at[1]); end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_exhaustive_n2();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
